// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

   localparam int unsigned BYTE_WIDTH       = 8;
   localparam int unsigned BYTES_PER_WORD   = 4;
   localparam int unsigned BYTE_COUNT_WIDTH = $clog2(BYTES_PER_WORD);

   typedef enum logic [2:0] {
      StIdle,
      StLength,
      StData,
      StWrite,
      StCheck,
      StDone,
      StError
   } loader_state_e;

   // States in which the loader takes bytes from the stream.
   function automatic logic accepts_bytes(loader_state_e s);
      return (s == StLength) || (s == StData) || (s == StCheck);
   endfunction

   // States in which a load is in flight.
   function automatic logic is_busy(loader_state_e s);
      return !((s == StIdle) || (s == StDone) || (s == StError));
   endfunction

   // The processor stays in reset during a load and after a failed one.
   function automatic logic holds_processor(loader_state_e s);
      return is_busy(s) || (s == StError);
   endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects stream bytes MSB first into one memory word.
module word_assembler
   import loader_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  shift_enable,
   input  logic [BYTE_WIDTH-1:0] data_byte,
   output logic [WORD_WIDTH-1:0] word,
   output logic                  word_complete
);

   logic [BYTE_COUNT_WIDTH-1:0] count_q;

   // Flags the byte that fills the word, so the FSM can leave DATA on that same edge.
   assign word_complete = shift_enable && (count_q == BYTE_COUNT_WIDTH'(BYTES_PER_WORD - 1));

   // Shift register and byte counter; the counter wraps naturally after the last byte.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         word    <= '0;
         count_q <= '0;
      end else if (shift_enable) begin
         word    <= {word[WORD_WIDTH-BYTE_WIDTH-1:0], data_byte};
         count_q <= count_q + BYTE_COUNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/program_loader.sv
// Loads word images from a byte stream into a memory write port.
// Optional trailing XOR checksum enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned WORD_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load_start,
   input  logic                  byte_valid,
   input  logic [BYTE_WIDTH-1:0] byte_data,
   output logic                  byte_ready,
   output logic                  mem_write_enable,
   output logic [ADDR_WIDTH-1:0] mem_write_address,
   output logic [WORD_WIDTH-1:0] mem_write_data,
   output logic                  processor_hold,
   output logic                  busy,
   output logic                  load_error,
   output logic [7:0]            words_written
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   localparam loader_state_e FinalState = StCheck;
`else
   localparam loader_state_e FinalState = StDone;
`endif

   loader_state_e         state_q, state_d;
   logic [BYTE_WIDTH-1:0] length_q;
   logic                  accept;
   logic                  load_accept;
   logic                  word_complete;
   logic [8:0]            written_next;
   logic                  last_word;

   assign accept       = byte_valid && byte_ready;
   assign load_accept  = load_start && !is_busy(state_q);
   assign written_next = {1'b0, words_written} + 9'd1;
   assign last_word    = written_next >= {1'b0, length_q};

   word_assembler #(
      .WORD_WIDTH (WORD_WIDTH)
   ) u_word_assembler (
      .clock         (clock),
      .reset         (reset),
      .clear         (load_accept),
      .shift_enable  (accept && (state_q == StData)),
      .data_byte     (byte_data),
      .word          (mem_write_data),
      .word_complete (word_complete)
   );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [BYTE_WIDTH-1:0] checksum_q;

   // Running XOR over the length byte and every data byte.
   always_ff @(posedge clock) begin
      if (reset || load_accept) begin
         checksum_q <= '0;
      end else if (accept && ((state_q == StLength) || (state_q == StData))) begin
         checksum_q <= checksum_q ^ byte_data;
      end
   end

   // Error flag mirrors the ERROR state, so load_start clears it on leaving.
   always_ff @(posedge clock) begin
      if (reset) begin
         load_error <= 1'b0;
      end else begin
         load_error <= (state_d == StError);
      end
   end
`else
   assign load_error = 1'b0;
`endif

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone, StError: begin
            if (load_accept) state_d = StLength;
         end
         StLength: begin
            if (accept) state_d = (byte_data == '0) ? FinalState : StData;
         end
         StData: begin
            if (word_complete) state_d = StWrite;
         end
         StWrite: begin
            state_d = last_word ? FinalState : StData;
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         StCheck: begin
            if (accept) state_d = (byte_data == checksum_q) ? StDone : StError;
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // State register; status outputs are registered from the next state so they change with it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q           <= StIdle;
         byte_ready        <= 1'b0;
         busy              <= 1'b0;
         processor_hold    <= 1'b0;
         mem_write_enable  <= 1'b0;
         mem_write_address <= '0;
         words_written     <= '0;
         length_q          <= '0;
      end else begin
         state_q          <= state_d;
         byte_ready       <= accepts_bytes(state_d);
         busy             <= is_busy(state_d);
         processor_hold   <= holds_processor(state_d);
         mem_write_enable <= (state_d == StWrite);
         if (load_accept) begin
            mem_write_address <= '0;
            words_written     <= '0;
         end else if (state_q == StWrite) begin
            // Address wraps modulo the memory size; later words overwrite earlier ones.
            mem_write_address <= mem_write_address + ADDR_WIDTH'(1);
            words_written     <= words_written + 8'd1;
         end
         if ((state_q == StLength) && accept) length_q <= byte_data;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

   localparam int unsigned ADDR_WIDTH = 6;
   localparam int unsigned WORD_WIDTH = 32;

   logic                  clock = 1'b0;
   logic                  reset;
   logic                  load_start;
   logic                  byte_valid;
   logic [7:0]            byte_data;
   logic                  byte_ready;
   logic                  mem_write_enable;
   logic [ADDR_WIDTH-1:0] mem_write_address;
   logic [WORD_WIDTH-1:0] mem_write_data;
   logic                  processor_hold;
   logic                  busy;
   logic                  load_error;
   logic [7:0]            words_written;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   logic [31:0]           mem [64];
   int                    strobes = 0;
   int                    proto_errors = 0;
   logic [ADDR_WIDTH-1:0] last_addr = '0;
   logic                  prev_we = 1'b0;

   always #5 clock = ~clock;

   program_loader #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WORD_WIDTH (WORD_WIDTH)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .load_start        (load_start),
      .byte_valid        (byte_valid),
      .byte_data         (byte_data),
      .byte_ready        (byte_ready),
      .mem_write_enable  (mem_write_enable),
      .mem_write_address (mem_write_address),
      .mem_write_data    (mem_write_data),
      .processor_hold    (processor_hold),
      .busy              (busy),
      .load_error        (load_error),
      .words_written     (words_written)
   );

   // Memory model fed by the write port; also flags multi-cycle strobes or ready during a write.
   always @(posedge clock) begin
      if (mem_write_enable) begin
         mem[mem_write_address] <= mem_write_data;
         strobes   <= strobes + 1;
         last_addr <= mem_write_address;
         if (prev_we || byte_ready) proto_errors <= proto_errors + 1;
      end
      prev_we <= mem_write_enable;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic start_load();
      load_start = 1'b1;
      @(negedge clock);
      load_start = 1'b0;
   endtask

   // Offers a byte until a ready edge takes it; returns on the negedge after acceptance.
   task automatic send_byte(input logic [7:0] b, input int max_gap);
      bit ok = 0;
      repeat ($urandom_range(0, max_gap)) @(negedge clock);
      byte_valid = 1'b1;
      byte_data  = b;
      for (int i = 0; i < 64 && !ok; i++) begin
         if (byte_ready) ok = 1;
         @(negedge clock);
      end
      byte_valid = 1'b0;
      byte_data  = 8'h5A;
      chk("byte_accepted", 64'(ok), 64'd1);
   endtask

   task automatic send_word(input logic [31:0] w, input int max_gap);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], max_gap);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && busy; i++) @(negedge clock);
      chk("wait_idle", 64'(busy), 64'd0);
   endtask

   int s0;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_DEAD;
      reset      = 1'b1;
      load_start = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      tick(3);
      reset = 1'b0;
      tick(10);

      // Reset values after idling.
      chk("rst_byte_ready", 64'(byte_ready), 64'd0);
      chk("rst_we", 64'(mem_write_enable), 64'd0);
      chk("rst_addr", 64'(mem_write_address), 64'd0);
      chk("rst_data", 64'(mem_write_data), 64'd0);
      chk("rst_hold", 64'(processor_hold), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_error", 64'(load_error), 64'd0);
      chk("rst_words", 64'(words_written), 64'd0);
      chk("rst_strobes", 64'(strobes), 64'd0);

      // N=2 back-to-back; checksum 02^12^34^56^78^9A^BC^DE^F0 = 0x02.
      s0 = strobes;
      start_load();
      chk("start_hold", 64'(processor_hold), 64'd1);
      chk("start_busy", 64'(busy), 64'd1);
      chk("start_ready", 64'(byte_ready), 64'd1);
      send_byte(8'h02, 0);
      send_word(32'h1234_5678, 0);
      send_word(32'h9ABC_DEF0, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(8'h02, 0);
      chk("hold_falls_after_checksum", 64'(processor_hold), 64'd0);
`endif
      wait_idle();
      chk("n2_mem0", 64'(mem[0]), 64'h1234_5678);
      chk("n2_mem1", 64'(mem[1]), 64'h9ABC_DEF0);
      chk("n2_words", 64'(words_written), 64'd2);
      chk("n2_hold", 64'(processor_hold), 64'd0);
      chk("n2_error", 64'(load_error), 64'd0);
      chk("n2_strobes", 64'(strobes - s0), 64'd2);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      // Corrupted checksum ends in ERROR with the processor still held.
      start_load();
      send_byte(8'h02, 0);
      send_word(32'h1234_5678, 0);
      send_word(32'h9ABC_DEF0, 0);
      send_byte(8'h03, 0);
      chk("err_flag", 64'(load_error), 64'd1);
      chk("err_hold", 64'(processor_hold), 64'd1);
      chk("err_busy", 64'(busy), 64'd0);
      chk("err_ready", 64'(byte_ready), 64'd0);
      start_load();
      chk("restart_clears_error", 64'(load_error), 64'd0);
      chk("restart_words", 64'(words_written), 64'd0);
      chk("restart_addr", 64'(mem_write_address), 64'd0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      chk("n0_done_hold", 64'(processor_hold), 64'd0);
      chk("n0_done_error", 64'(load_error), 64'd0);
`else
      start_load();
      send_byte(8'h00, 0);
      chk("n0_done_hold", 64'(processor_hold), 64'd0);
      chk("n0_done_busy", 64'(busy), 64'd0);
`endif

      // N=65 with word index as data: addr 0 is overwritten by word 64.
      // Checksum 0x41 ^ (XOR of 0..64 = 0x40) = 0x01.
      s0 = strobes;
      start_load();
      send_byte(8'd65, 0);
      for (int i = 0; i < 65; i++) send_word(32'(i), 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(8'h01, 0);
`endif
      wait_idle();
      chk("wrap_mem0", 64'(mem[0]), 64'h40);
      chk("wrap_mem1", 64'(mem[1]), 64'h01);
      chk("wrap_mem63", 64'(mem[63]), 64'h3F);
      chk("wrap_words", 64'(words_written), 64'd65);
      chk("wrap_strobes", 64'(strobes - s0), 64'd65);
      chk("wrap_error", 64'(load_error), 64'd0);

      // Bytes offered in DONE are not taken; random gaps and a busy load_start change nothing.
      byte_valid = 1'b1;
      byte_data  = 8'h77;
      tick(3);
      chk("done_ready", 64'(byte_ready), 64'd0);
      byte_valid = 1'b0;
      mem[0] = 32'hDEAD_DEAD;
      mem[1] = 32'hDEAD_DEAD;
      s0 = strobes;
      start_load();
      send_byte(8'h02, 3);
      send_word(32'h1234_5678, 3);
      start_load();
      send_word(32'h9ABC_DEF0, 3);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(8'h02, 3);
`endif
      wait_idle();
      chk("gap_mem0", 64'(mem[0]), 64'h1234_5678);
      chk("gap_mem1", 64'(mem[1]), 64'h9ABC_DEF0);
      chk("gap_words", 64'(words_written), 64'd2);
      chk("gap_strobes", 64'(strobes - s0), 64'd2);
      chk("gap_error", 64'(load_error), 64'd0);

      // Reset after 6 data bytes aborts with no further strobe.
      start_load();
      send_byte(8'h02, 0);
      for (int i = 0; i < 6; i++) send_byte(8'(8'h11 + i), 0);
      s0 = strobes;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_hold", 64'(processor_hold), 64'd0);
      chk("abort_ready", 64'(byte_ready), 64'd0);
      chk("abort_we", 64'(mem_write_enable), 64'd0);
      chk("abort_words", 64'(words_written), 64'd0);
      chk("abort_addr", 64'(mem_write_address), 64'd0);
      tick(2);
      chk("abort_no_strobe", 64'(strobes - s0), 64'd0);

      // Fresh N=1 load; checksum 01^CA^FE^BA^BE = 0x31.
      start_load();
      send_byte(8'h01, 0);
      send_word(32'hCAFE_BABE, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(8'h31, 0);
`endif
      wait_idle();
      chk("fresh_mem0", 64'(mem[0]), 64'hCAFE_BABE);
      chk("fresh_addr", 64'(last_addr), 64'd0);
      chk("fresh_words", 64'(words_written), 64'd1);
      chk("strobe_protocol", 64'(proto_errors), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/program_loader.md
# program_loader

Writes program and data images into the computer's word-addressed memories from a byte stream; it is the writer to the existing display read ports. It sits beside `computer`: it takes bytes from a host link (UART receiver or switch/key front end) and drives one memory write port. While loading, it holds the processor in reset.

## Interface
- `ADDR_WIDTH`, 6: word-address width of the target memory (64 words).
- `WORD_WIDTH`, 32: memory word width. Fixed at 4 bytes.
- `clock` input 1: system clock. All logic is rising-edge.
- `reset` input 1: synchronous, active-high. Returns the block to IDLE.
- `load_start` input 1: single-cycle request to begin a load. Ignored unless in IDLE, DONE or ERROR.
- `byte_valid` input 1: `byte_data` is valid this cycle.
- `byte_data` input 8: stream byte.
- `byte_ready` output 1: loader accepts a byte this cycle.
- `mem_write_enable` output 1: one-cycle write strobe.
- `mem_write_address` output ADDR_WIDTH: word address of the write.
- `mem_write_data` output WORD_WIDTH: word to write.
- `processor_hold` output 1: connect to processor reset. High while a load is in progress or failed.
- `busy` output 1: high in any state except IDLE, DONE and ERROR.
- `load_error` output 1: sticky checksum failure. Cleared by `reset` or the next `load_start`.
- `words_written` output 8: count of words written in the current load.

## Operation
- Byte transfer occurs when `byte_valid && byte_ready` on a rising edge. `byte_data` is sampled only on that edge.
- States:
  - IDLE: `byte_ready`=0. `load_start` → LENGTH.
  - LENGTH: `byte_ready`=1. The accepted byte is N, the number of words. N=0 → CHECK (macro on) or DONE (macro off). Otherwise → DATA.
  - DATA: `byte_ready`=1. Accept 4 bytes, MSB first, shifting each into the word register. After the 4th byte → WRITE.
  - WRITE: `byte_ready`=0. `mem_write_enable`=1 for exactly this cycle. Address and data are stable for the whole cycle.
    - Next edge: address += 1, `words_written` += 1.
    - Then → DATA if `words_written` < N, else → CHECK or DONE.
  - CHECK: `byte_ready`=1. Accept one byte and compare it to the running checksum. Match → DONE, mismatch → ERROR.
  - DONE: `processor_hold`=0.
  - ERROR: `processor_hold`=1, `load_error`=1.
- `load_start` in DONE or ERROR does the following: clears `load_error`, `words_written`, the address and the checksum; enters LENGTH.
- The address starts at 0 and wraps modulo 2^ADDR_WIDTH. With N > 64 the later words overwrite the earlier ones; this is legal and not an error.
- `load_start` while busy is ignored. `byte_valid` in IDLE, WRITE, DONE or ERROR is ignored; the byte is not consumed.
- `reset` mid-load aborts the load at once. A write strobe is never issued on the reset edge or the following cycle.

## Timing
- Reset values:
  - state IDLE
  - `byte_ready`=0, `mem_write_enable`=0
  - `mem_write_address`=0, `mem_write_data`=0
  - `processor_hold`=0, `busy`=0, `load_error`=0, `words_written`=0
- `processor_hold` rises on the edge that accepts `load_start` (entering LENGTH). It falls on the edge entering DONE.
- Write latency: the strobe is asserted in the cycle after the edge that accepts the 4th byte. There is one mandatory bubble (`byte_ready`=0) per word.
- Peak throughput is 4 bytes per 5 cycles.
- All outputs are registered. `byte_ready` is decoded from registered state only, with no combinational path from `byte_valid`.

## Configuration
- Macro `PROGRAM_LOADER_CHECKSUM_EN`.
  - Defined: the running XOR of the N byte and all data bytes is kept. The CHECK state and ERROR state exist, and `load_error` can assert.
  - Undefined: after the last WRITE (or after N=0) the FSM goes straight to DONE. `load_error` is tied to 0, the ERROR state is absent, and no trailing byte is consumed.

## Structure
- Package `loader_pkg` holds:
  - the state enum (IDLE, LENGTH, DATA, WRITE, CHECK, DONE, ERROR)
  - `BYTES_PER_WORD`=4
  - the byte width constant
- Sub-module `word_assembler` contains the 32-bit shift register and the 2-bit byte counter. It has a `clear` input and outputs `word` and `word_complete`. The FSM, address counter and checksum stay in `program_loader`.

## Test plan
- Reset, then idle for 10 cycles → all outputs at their reset values; no write strobes.
- Load N=2 with bytes 12 34 56 78 9A BC DE F0 and a correct checksum → two writes: addr 0 = 0x12345678, addr 1 = 0x9ABCDEF0. `processor_hold` falls in the cycle after the checksum byte is accepted. `words_written`=2.
- Same stream with a checksum byte XOR 0x01 (macro on) → ERROR, `load_error`=1, `processor_hold` stays 1. A following `load_start` clears `load_error`.
- N=65 with the word index as data → addr 0 finally holds 0x00000040 (wrap). 65 strobes are issued. `words_written`=65.
- Random `byte_valid` gaps and back-to-back bytes → identical memory contents. No byte is consumed while `byte_ready`=0.
- `reset` asserted after 6 data bytes → IDLE on the next edge; no strobe; a fresh N=1 load writes to addr 0.
